// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; head reads as zero while empty.
module sync_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [63:0]
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // a push into a full FIFO is fine when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock)
    if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, issues credited reads to imem, buffers words for decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic        halted
);
  localparam int             CW    = $clog2(DEPTH) + 1;
  localparam logic [CW:0]    LIMIT = (CW+1)'(DEPTH);

  state_t            state, state_nx;
  logic [XLEN-1:0]   fetch_pc, resp_pc;
  logic [CW-1:0]     count, inflight, drop_cnt, inflight_nx, redirect_drop;
  logic [CW:0]       occupancy;
  logic              req_fire, resp_fire, dropping, push, pop, halt_push;
  logic              fifo_full, fifo_empty;
  fetch_entry_t      push_entry, head;

  assign occupancy      = {1'b0, count} + {1'b0, inflight};
  assign imem_req_valid = !reset && (state != HALTED) && !redirect_valid && (occupancy < LIMIT);
  assign imem_req_addr  = fetch_pc;

  assign req_fire   = imem_req_valid && imem_req_ready;
  // a response with nothing outstanding is noise and is ignored
  assign resp_fire  = imem_resp_valid && (inflight != '0);
  assign dropping   = (drop_cnt != '0);
  assign push       = resp_fire && !dropping && !redirect_valid;
  assign halt_push  = push && (imem_resp_data == HALT_INSTR);
  assign pop        = out_valid && out_ready && !redirect_valid;
  assign push_entry = '{pc: resp_pc, instr: imem_resp_data};

  assign inflight_nx   = inflight + CW'(req_fire) - CW'(resp_fire);
  assign redirect_drop = inflight - CW'(resp_fire);

  assign out_valid       = !fifo_empty;
  assign out_instruction = head.instr;
  assign out_pc          = head.pc;
  assign halted          = (state == HALTED);

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (redirect_valid)
      state_nx = (redirect_drop != '0) ? DRAIN : RUN;
    else if (halt_push)
      state_nx = HALTED;
    else if (state == DRAIN && resp_fire && drop_cnt == CW'(1))
      state_nx = RUN;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight_nx;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        resp_pc  <= {redirect_pc[31:2], 2'b00};
        drop_cnt <= redirect_drop;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push)     resp_pc  <= resp_pc + 32'd4;
        // everything still outstanding after the halt word belongs to the dead path
        if (halt_push)                  drop_cnt <= inflight_nx;
        else if (resp_fire && dropping) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  sync_fifo #(.DEPTH(DEPTH), .entry_t(fetch_entry_t)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && fifo_full && !pop));
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue with a queue-level model of the fetch stage.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] HALT     = 32'hFFFF_FFFF;

  logic        clock, reset, redirect_valid, imem_req_valid, imem_req_ready;
  logic        imem_resp_valid, out_valid, out_ready, halted;
  logic [31:0] redirect_pc, imem_req_addr, imem_resp_data, out_instruction, out_pc;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_pc(out_pc), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { logic [31:0] addr; logic [31:0] data; int due; } mreq_t;
  typedef struct { logic [31:0] addr; bit stale; } ost_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  mreq_t       mq[$];
  ost_t        outs[$];
  ent_t        expq[$], out_log[$];
  logic [31:0] req_log[$];
  logic [31:0] m_pc;
  bit          m_halted, model_ok;

  int checks = 0, failures = 0, cyc = 0;
  int p_rdy = 100, p_resp = 100, p_out = 100, lat_min = 1, lat_max = 1;
  int p_redir = 0, p_rst = 0, p_spur = 0;
  bit force_reset = 1, force_redir = 0, halt_en = 0;
  logic [31:0] fr_pc = 0, halt_addr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit pct(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [31:0] v;
    if (halt_en && a == halt_addr) return HALT;
    v = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    if (v == HALT) v = 32'h0;
    return v;
  endfunction

  // environment driver: memory, decode back-pressure, redirects, resets
  initial begin
    reset = 1; redirect_valid = 0; redirect_pc = 0; imem_req_ready = 0;
    imem_resp_valid = 0; imem_resp_data = 0; out_ready = 0;
    forever begin
      @(posedge clock); cyc++; #1;
      reset          = force_reset || (int'($urandom_range(999)) < p_rst);
      imem_req_ready = pct(p_rdy);
      out_ready      = pct(p_out);
      redirect_valid = force_redir || pct(p_redir);
      redirect_pc    = force_redir ? fr_pc : ($urandom() & 32'h0000_03FF);
      if (mq.size() != 0 && mq[0].due <= cyc && pct(p_resp)) begin
        imem_resp_valid = 1; imem_resp_data = mq[0].data;
      end else if (mq.size() == 0 && pct(p_spur)) begin
        imem_resp_valid = 1; imem_resp_data = $urandom();
      end else begin
        imem_resp_valid = 0; imem_resp_data = $urandom();
      end
    end
  end

  // compare against the model, then advance model and memory by the coming edge
  always @(negedge clock) begin
    bit    exp_rv, has;
    ost_t  o;
    ent_t  e;
    mreq_t m;
    exp_rv = !reset && !m_halted && !redirect_valid && (expq.size() + outs.size() < DEPTH);
    if (model_ok) begin
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
      chk("out_valid", 32'(out_valid), 32'(expq.size() != 0));
      if (expq.size() != 0) begin
        chk("out_pc", out_pc, expq[0].pc);
        chk("out_instr", out_instruction, expq[0].instr);
      end
      chk("halted", 32'(halted), 32'(m_halted));
    end

    if (reset) mq.delete();
    else begin
      if (imem_resp_valid && mq.size() != 0) mq.delete(0);
      if (imem_req_valid && imem_req_ready) begin
        m.addr = imem_req_addr; m.data = memf(imem_req_addr);
        m.due  = cyc + int'($urandom_range(lat_max, lat_min));
        mq.push_back(m);
        req_log.push_back(imem_req_addr);
      end
      if (out_valid && out_ready && !redirect_valid) begin
        e.pc = out_pc; e.instr = out_instruction; out_log.push_back(e);
      end
    end

    if (reset) begin
      outs.delete(); expq.delete(); m_pc = RESET_PC; m_halted = 0; model_ok = 1;
    end else if (redirect_valid) begin
      if (imem_resp_valid && outs.size() != 0) outs.delete(0);
      foreach (outs[i]) outs[i].stale = 1;
      expq.delete();
      m_pc = {redirect_pc[31:2], 2'b00};
      m_halted = 0;
    end else begin
      has = outs.size() != 0;
      if (expq.size() != 0 && out_ready) expq.delete(0);
      if (exp_rv && imem_req_ready) begin
        o.addr = m_pc; o.stale = 0; outs.push_back(o); m_pc += 32'd4;
      end
      if (imem_resp_valid && has) begin
        o = outs[0]; outs.delete(0);
        if (!o.stale) begin
          e.pc = o.addr; e.instr = imem_resp_data; expq.push_back(e);
          if (imem_resp_data == HALT) begin
            m_halted = 1;
            foreach (outs[i]) outs[i].stale = 1;
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    force_reset = 1;
    cycles(2);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instruction, 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    force_reset = 0;
    req_log.delete(); out_log.delete();
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    force_redir = 1; fr_pc = pc;
    cycles(1);
    force_redir = 0;
  endtask

  task automatic wait_out(input int n, input string nm);
    int budget = 60;
    while (out_log.size() < n && budget > 0) begin cycles(1); budget--; end
    if (out_log.size() < n) begin
      checks++; failures++;
      $display("FAIL %s: timeout with %0d outputs, wanted %0d", nm, out_log.size(), n);
    end
  endtask

  initial begin
    int n;
    // zero-latency memory, decode always ready
    do_reset();
    cycles(3);
    for (int i = 0; i < 6; i++) begin
      chk("t1_valid", 32'(out_valid), 32'h1);
      chk("t1_pc", out_pc, 32'(i * 4));
      cycles(1);
    end

    // decode stalled: credit limit caps issue at DEPTH words
    p_out = 0;
    do_reset();
    cycles(12);
    chk("t2_nreq", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_addr", req_log[i], 32'(i * 4));
    chk("t2_req_valid", 32'(imem_req_valid), 32'h0);
    p_out = 100;
    cycles(3);
    chk("t2_fifth", req_log[4], 32'h10);

    // 3-cycle memory, redirect with three reads in flight
    lat_min = 3; lat_max = 3;
    do_reset();
    cycles(3);
    out_log.delete();
    redirect_to(32'h40);
    wait_out(1, "t3_wait");
    chk("t3_first_pc", out_log[0].pc, 32'h40);
    chk("t3_first_instr", out_log[0].instr, memf(32'h40));

    // unaligned redirect coincident with a response
    lat_min = 1; lat_max = 1;
    do_reset();
    cycles(6);
    redirect_to(32'h43);
    out_log.delete();
    cycles(1);
    chk("t4_req_addr", imem_req_addr, 32'h40);
    wait_out(1, "t4_wait");
    chk("t4_first_pc", out_log[0].pc, 32'h40);

    // halt word at 0x8
    halt_en = 1; halt_addr = 32'h8; lat_min = 3; lat_max = 3;
    do_reset();
    n = 40;
    while (!halted && n > 0) begin cycles(1); n--; end
    chk("t5_halted", 32'(halted), 32'h1);
    n = req_log.size();
    cycles(15);
    chk("t5_no_more_req", 32'(req_log.size()), 32'(n));
    chk("t5_nout", 32'(out_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("t5_pc", out_log[i].pc, 32'(i * 4));
    chk("t5_halt_instr", out_log[2].instr, HALT);
    halt_en = 0;
    redirect_to(32'h0);
    cycles(1);
    chk("t5_resume_valid", 32'(imem_req_valid), 32'h1);
    chk("t5_resume_addr", imem_req_addr, 32'h0);
    chk("t5_unhalted", 32'(halted), 32'h0);

    // PC wrap, then reset in the middle of a burst
    lat_min = 1; lat_max = 1; p_out = 0;
    redirect_to(32'hFFFF_FFF8);
    req_log.delete();
    cycles(8);
    chk("t6_wrap0", req_log[0], 32'hFFFF_FFF8);
    chk("t6_wrap1", req_log[1], 32'hFFFF_FFFC);
    chk("t6_wrap2", req_log[2], 32'h0000_0000);
    p_out = 100;
    cycles(2);
    do_reset();
    cycles(1);
    chk("t6_rst_addr", imem_req_addr, RESET_PC);
    chk("t6_rst_valid", 32'(imem_req_valid), 32'h1);
    chk("t6_rst_out_valid", 32'(out_valid), 32'h0);

    // randomized segments, checked every cycle by the model
    for (int s = 0; s < 10; s++) begin
      p_rdy = int'($urandom_range(100, 30)); p_resp = int'($urandom_range(100, 30));
      p_out = int'($urandom_range(100, 20)); lat_min = 1; lat_max = int'($urandom_range(5, 1));
      p_redir = int'($urandom_range(5, 1)); p_rst = int'($urandom_range(3, 0));
      p_spur = int'($urandom_range(20, 0));
      halt_en = (s % 3 == 0); halt_addr = 32'($urandom_range(63, 0)) << 2;
      cycles(400);
    end
    p_redir = 0; p_rst = 0; p_spur = 0; halt_en = 0;
    cycles(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Fetch stage between instruction memory and decode/instruction register.
- Owns the fetch PC and issues pipelined word reads to a latency-variable instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned words with their PC in a small FIFO and presents them to decode over a valid/ready channel.
- Supports redirect (branch/jal/jalr) flush with discard of in-flight responses; stops fetching after the halt word.

Parameters:
- DEPTH, 4, FIFO entries and maximum outstanding-plus-buffered words (power of 2, ≥2)
- RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] forced to 0
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word-aligned read address
- imem_resp_valid  in  1  read data valid (in order, one per accepted request)
- imem_resp_data  in  32  instruction word
- out_valid  out  1  head entry valid
- out_ready  in  1  decode consumes head
- out_instruction  out  32  head instruction
- out_pc  out  32  head PC
- halted  out  1  halt word has been enqueued; fetching stopped

Behaviour:
- Reset values:
  - fetch_pc = resp_pc = RESET_PC.
  - count = inflight = drop_cnt = 0; halted = 0.
  - imem_req_valid = 0 in the reset cycle; out_valid = 0; out_instruction = 0; out_pc = 0.
- Reset mid-operation clears everything. Responses arriving while inflight == 0 are ignored.
- State machine (state_t):
  - RUN: normal operation.
  - DRAIN: drop_cnt > 0; responses are discarded.
  - HALTED: no requests issued.
  - RUN→DRAIN on redirect with surviving in-flight responses. DRAIN→RUN when drop_cnt reaches 0.
  - RUN→HALTED when the halt word is pushed.
  - Any state→RUN or DRAIN on redirect, which clears halted.
- Request channel:
  - imem_req_valid = (state != HALTED) && !redirect_valid && (count + inflight < DEPTH).
  - imem_req_addr = fetch_pc.
  - On a request handshake: fetch_pc += 4 (mod 2^32, wraps from FFFF_FFFC to 0) and inflight++.
  - imem_req_valid and imem_req_addr hold stable until the handshake, unless a redirect occurs.
- Response (when not dropping):
  - Push {resp_pc, imem_resp_data}, then resp_pc += 4 and inflight--.
  - Space is guaranteed by the credit rule. An overflow is an assertion failure.
- Response while drop_cnt > 0: discard, drop_cnt--, inflight--.
- Halt:
  - A pushed word equal to HALT_INSTR (32'hFFFF_FFFF) sets halted.
  - Later non-dropped responses from earlier requests are discarded: drop_cnt = remaining inflight.
  - Entries already queued still drain to decode, including the halt word itself.
- Output:
  - out_valid = (count != 0); out_instruction and out_pc come from the FIFO head.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle are legal at any fill level, including full; count is unchanged.
  - Combinational bypass from response to output is not allowed. Minimum latency is request handshake → response → out_valid on the next edge.
- Redirect cycle (highest priority):
  - FIFO cleared; fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
  - drop_cnt = inflight − (resp this cycle ? 1 : 0). A response in that same cycle is discarded.
  - No request and no pop take effect in that cycle; out_ready is ignored.
  - Redirect in DRAIN accumulates: drop_cnt = current inflight − resp.
- Widths: count, inflight and drop_cnt are $clog2(DEPTH)+1 bits.

Decomposition:
- Package fetch_pkg:
  - XLEN = 32, INSTR_W = 32, HALT_INSTR = 32'hFFFF_FFFF.
  - typedef fetch_entry_t {pc, instr}.
  - enum state_t {RUN, DRAIN, HALTED}.
- Sub-module sync_fifo: parameterised DEPTH and entry type, with push, pop, flush, count, full and empty outputs. It is reusable by a future data-memory write buffer.

Test Plan:
- Reset, zero-latency memory, out_ready=1, program at 0/4/8 → out_pc 0, 4, 8 on consecutive cycles after the first response; no gaps in steady state.
- out_ready=0 with memory always ready → exactly 4 requests issued (addresses 0, 4, 8, C). imem_req_valid drops; count=4; no fifth request until a pop.
- Memory latency 3 cycles, 3 in flight, redirect_pc=0x40 → 3 stale responses discarded, out_valid stays 0, first out_pc=0x40.
- redirect_pc=0x43 coincident with a response → fetch resumes at 0x40 and the coincident response is dropped.
- Word at 0x8 = FFFF_FFFF with 2 later requests outstanding → halted=1; out sequence 0, 4, 8 (instr FFFF_FFFF); no further requests; redirect to 0x0 resumes fetching.
- fetch_pc=FFFF_FFF8, two fetches → addresses FFFF_FFF8, FFFF_FFFC, then 0000_0000; reset asserted mid-burst → next request address = RESET_PC and out_valid=0.
